// File: rtl/traffic_light_ctrl_if.sv
// Bundles the traffic light control inputs and the registered light outputs.
// The master drives the run/night/pedestrian controls; the slave (the controller)
// drives the LED, phase, walk and pending-request outputs.
interface traffic_light_ctrl_if;
  logic       en;
  logic       night_mode;
  logic       ped_req;
  logic [2:0] led;
  logic [1:0] phase;
  logic       walk;
  logic       ped_pend;

  modport master (
    output en,
    output night_mode,
    output ped_req,
    input  led,
    input  phase,
    input  walk,
    input  ped_pend
  );

  modport slave (
    input  en,
    input  night_mode,
    input  ped_req,
    output led,
    output phase,
    output walk,
    output ped_pend
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Parametrised RED -> GREEN -> CAUTION traffic light controller.
// Phase durations are counted in prescaled ticks. A latched pedestrian request
// shortens GREEN, night mode flashes the caution light, and en=0 freezes
// everything. The LED output is active-low: led[2]=blue, led[1]=red, led[0]=green.
// All outputs are registered and are computed from the next state, so they
// change on the same edge as the state itself.
module traffic_light_ctrl #(
  parameter int CLK_DIV   = 1,
  parameter int CNT_W     = 8,
  parameter int RED_T     = 10,
  parameter int GREEN_T   = 5,
  parameter int CAUTION_T = 2,
  parameter int MIN_GREEN = 2,
  parameter int FLASH_T   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  traffic_light_ctrl_if.slave   tl
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RED_LAST     = CNT_W'(RED_T - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] CAUTION_LAST = CNT_W'(CAUTION_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(FLASH_T - 1);
  localparam logic [CNT_W-1:0] MIN_G_LAST   = CNT_W'(MIN_GREEN - 1);

  localparam logic [2:0] LED_RED     = 3'b101;
  localparam logic [2:0] LED_GREEN   = 3'b110;
  localparam logic [2:0] LED_CAUTION = 3'b011;
  localparam logic [2:0] LED_OFF     = 3'b111;

  // Encoding doubles as the phase output value.
  typedef enum logic [1:0] {
    ST_RED     = 2'd0,
    ST_GREEN   = 2'd1,
    ST_CAUTION = 2'd2,
    ST_NIGHT   = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic             ped_pend_q, ped_pend_d;
  logic             flash_q,    flash_d;
  logic [2:0]       led_q,      led_d;
  logic [1:0]       phase_q,    phase_d;
  logic             walk_q,     walk_d;

  logic             tick_s;
  logic             phase_end_s;
  logic             ped_cut_s;
  logic [CNT_W-1:0] phase_last_s;
  state_e           next_phase_s;

  // Last tick index of the current normal phase and the phase that follows it.
  always_comb begin
    phase_last_s = RED_LAST;
    next_phase_s = ST_GREEN;
    case (state_q)
      ST_RED: begin
        phase_last_s = RED_LAST;
        next_phase_s = ST_GREEN;
      end
      ST_GREEN: begin
        phase_last_s = GREEN_LAST;
        next_phase_s = ST_CAUTION;
      end
      ST_CAUTION: begin
        phase_last_s = CAUTION_LAST;
        next_phase_s = ST_RED;
      end
      default: begin
        phase_last_s = RED_LAST;
        next_phase_s = ST_RED;
      end
    endcase
  end

  // Prescaler tick, phase completion and pedestrian cut conditions.
  always_comb begin
    tick_s      = (div_q == DIV_LAST);
    phase_end_s = (cnt_q == phase_last_s);
    ped_cut_s   = (state_q == ST_GREEN) && ped_pend_q && (cnt_q >= MIN_G_LAST);
  end

  // Next-state logic: night mode overrides the normal cycle; the register
  // stage applies these values only while en=1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    ped_pend_d = ped_pend_q;
    flash_d    = flash_q;

    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (tl.night_mode) begin
      // Pedestrian requests are dropped for the whole night period.
      ped_pend_d = 1'b0;
      if (state_q != ST_NIGHT) begin
        state_d = ST_NIGHT;
        cnt_d   = '0;
        flash_d = 1'b1;
      end else if (tick_s) begin
        if (cnt_q == FLASH_LAST) begin
          cnt_d   = '0;
          flash_d = ~flash_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q;
      end
    end else if (state_q == ST_NIGHT) begin
      // Leaving night restarts safely with a full RED phase.
      state_d    = ST_RED;
      cnt_d      = '0;
      flash_d    = 1'b1;
      ped_pend_d = 1'b0;
    end else begin
      ped_pend_d = ped_pend_q | tl.ped_req;
      if (tick_s) begin
        if (phase_end_s || ped_cut_s) begin
          state_d = next_phase_s;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q;
      end
      // Entering RED serves the request; this wins over a coincident ped_req.
      if ((state_d == ST_RED) && (state_q != ST_RED)) begin
        ped_pend_d = 1'b0;
      end else begin
        ped_pend_d = ped_pend_d;
      end
    end
  end

  // Output decode from the next state so outputs track the state edge exactly.
  always_comb begin
    led_d   = LED_OFF;
    phase_d = 2'(state_d);
    walk_d  = (state_d == ST_RED);
    case (state_d)
      ST_RED:     led_d = LED_RED;
      ST_GREEN:   led_d = LED_GREEN;
      ST_CAUTION: led_d = LED_CAUTION;
      ST_NIGHT: begin
        if (flash_d) begin
          led_d = LED_CAUTION;
        end else begin
          led_d = LED_OFF;
        end
      end
      default:    led_d = LED_OFF;
    endcase
  end

  // State, counter and output registers: reset first, then hold while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RED;
      cnt_q      <= '0;
      div_q      <= '0;
      ped_pend_q <= 1'b0;
      flash_q    <= 1'b1;
      led_q      <= LED_RED;
      phase_q    <= 2'd0;
      walk_q     <= 1'b1;
    end else if (tl.en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      ped_pend_q <= ped_pend_d;
      flash_q    <= flash_d;
      led_q      <= led_d;
      phase_q    <= phase_d;
      walk_q     <= walk_d;
    end
  end

  assign tl.led      = led_q;
  assign tl.phase    = phase_q;
  assign tl.walk     = walk_q;
  assign tl.ped_pend = ped_pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl. Two instances run side by side
// from the same stimulus: one with CLK_DIV=1, one with CLK_DIV=4. A reference
// model counts enabled cycles and elapsed ticks per phase and predicts every
// output after each clock edge.
module tb_traffic_light_ctrl;

  localparam int RED_T     = 10;
  localparam int GREEN_T   = 5;
  localparam int CAUTION_T = 2;
  localparam int MIN_GREEN = 2;
  localparam int FLASH_T   = 1;

  logic clk;
  logic rst_s;
  logic en_s;
  logic night_s;
  logic ped_s;

  int total;
  int bad;

  // Reference model state per instance: 0 -> CLK_DIV=1, 1 -> CLK_DIV=4.
  int m_ph   [2];   // 0 red, 1 green, 2 caution, 3 night
  int m_tk   [2];   // ticks elapsed in current phase / flash half-period
  bit m_lit  [2];
  bit m_pend [2];
  int m_encnt[2];   // enabled clocks since reset

  traffic_light_ctrl_if if1 ();
  traffic_light_ctrl_if if4 ();

  assign if1.en         = en_s;
  assign if1.night_mode = night_s;
  assign if1.ped_req    = ped_s;
  assign if4.en         = en_s;
  assign if4.night_mode = night_s;
  assign if4.ped_req    = ped_s;

  traffic_light_ctrl #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst_s), .tl(if1));
  traffic_light_ctrl #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst_s), .tl(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dur(input int ph);
    case (ph)
      0:       return RED_T;
      1:       return GREEN_T;
      default: return CAUTION_T;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance model k by one clock using the inputs present before the edge.
  task automatic model_step(input int k);
    int  div;
    bit  tick;
    bit  np;
    bit  cut;
    int  old_ph;
    div = (k == 0) ? 1 : 4;
    if (rst_s) begin
      m_ph[k] = 0; m_tk[k] = 0; m_lit[k] = 1'b1; m_pend[k] = 1'b0; m_encnt[k] = 0;
    end else if (en_s) begin
      tick = ((m_encnt[k] % div) == (div - 1));
      m_encnt[k]++;
      if (night_s) begin
        m_pend[k] = 1'b0;
        if (m_ph[k] != 3) begin
          m_ph[k] = 3; m_tk[k] = 0; m_lit[k] = 1'b1;
        end else if (tick) begin
          m_tk[k]++;
          if (m_tk[k] == FLASH_T) begin
            m_tk[k] = 0; m_lit[k] = !m_lit[k];
          end
        end
      end else if (m_ph[k] == 3) begin
        m_ph[k] = 0; m_tk[k] = 0; m_pend[k] = 1'b0; m_lit[k] = 1'b1;
      end else begin
        old_ph = m_ph[k];
        np = m_pend[k] | ped_s;
        if (tick) begin
          m_tk[k]++;
          cut = (m_ph[k] == 1) && m_pend[k] && (m_tk[k] >= MIN_GREEN);
          if ((m_tk[k] == dur(m_ph[k])) || cut) begin
            m_ph[k] = (m_ph[k] + 1) % 3;
            m_tk[k] = 0;
          end
        end
        if (m_ph[k] == 0 && old_ph != 0) np = 1'b0;
        m_pend[k] = np;
      end
    end
  endtask

  function automatic logic [2:0] exp_led(input int k);
    case (m_ph[k])
      0:       return 3'b101;
      1:       return 3'b110;
      2:       return 3'b011;
      default: return m_lit[k] ? 3'b011 : 3'b111;
    endcase
  endfunction

  task automatic check_all();
    chk("led_div1",   {5'd0, if1.led},      {5'd0, exp_led(0)});
    chk("phase_div1", {6'd0, if1.phase},    8'(m_ph[0]));
    chk("walk_div1",  {7'd0, if1.walk},     {7'd0, (m_ph[0] == 0)});
    chk("pend_div1",  {7'd0, if1.ped_pend}, {7'd0, m_pend[0]});
    chk("led_div4",   {5'd0, if4.led},      {5'd0, exp_led(1)});
    chk("phase_div4", {6'd0, if4.phase},    8'(m_ph[1]));
    chk("walk_div4",  {7'd0, if4.walk},     {7'd0, (m_ph[1] == 0)});
    chk("pend_div4",  {7'd0, if4.ped_pend}, {7'd0, m_pend[1]});
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the CLK_DIV=1 model sits in phase ph with tk elapsed ticks.
  task automatic wait_for(input string tag, input int ph, input int tk);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_ph[0] == ph && m_tk[0] == tk) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk(tag, {7'd0, found}, 8'd1);
  endtask

  initial begin
    int green_len;
    total = 0; bad = 0;
    rst_s = 1'b1; en_s = 1'b1; night_s = 1'b0; ped_s = 1'b0;

    // Reset and free run through two full cycles.
    run(2);
    chk("reset_led", {5'd0, if1.led}, 8'h05);
    chk("reset_walk", {7'd0, if1.walk}, 8'd1);
    rst_s = 1'b0;
    run(40);

    // One-clock pedestrian request at the start of GREEN.
    wait_for("wait_green0", 1, 0);
    ped_s = 1'b1;
    step();
    ped_s = 1'b0;
    green_len = 1;
    while (m_ph[0] == 1 && green_len < 10) begin
      step();
      green_len++;
    end
    chk("ped_green_len", 8'(green_len), 8'(MIN_GREEN));
    run(20);

    // Request during RED carries over to cut the next GREEN.
    wait_for("wait_red3", 0, 3);
    ped_s = 1'b1;
    step();
    ped_s = 1'b0;
    chk("ped_held_red", {7'd0, if1.ped_pend}, 8'd1);
    run(25);

    // Request coincident with RED entry is discarded.
    wait_for("wait_caut_last", 2, CAUTION_T - 1);
    ped_s = 1'b1;
    step();
    ped_s = 1'b0;
    chk("ped_clear_wins", {7'd0, if1.ped_pend}, 8'd0);
    run(10);

    // Night mode entered mid-GREEN, then restart into a full RED.
    wait_for("wait_green1", 1, 1);
    night_s = 1'b1;
    step();
    chk("night_phase", {6'd0, if1.phase}, 8'd3);
    ped_s = 1'b1;
    run(8);
    ped_s = 1'b0;
    night_s = 1'b0;
    run(15);

    // Freeze for 7 clocks inside RED, then resume.
    wait_for("wait_red4", 0, 4);
    en_s = 1'b0;
    ped_s = 1'b1;
    run(7);
    ped_s = 1'b0;
    en_s = 1'b1;
    run(15);

    // Reset during CAUTION.
    wait_for("wait_caution", 2, 0);
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    chk("rst_caution_led", {5'd0, if1.led}, 8'h05);
    run(5);

    // Randomised traffic: mostly enabled, occasional night toggles and resets.
    for (int i = 0; i < 800; i++) begin
      en_s  = ($urandom_range(0, 9) != 0);
      ped_s = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) night_s = ~night_s;
      rst_s = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
